sync_down_timer8: RTL and testbench
===================================

# sync_down_timer8

- Loadable synchronous down-counter/timer.
- The counterpart of the team's synchronous T-flip-flop up-counter: same borrow-chain structure, counting the other direction.
- Counts a loaded value down to zero, flags expiry with a one-cycle pulse and then idles. In the auto-reload build it restarts from the stored value instead of idling.
- Used as a programmable delay / clock-enable divider next to the up-counter in the timing subsystem.

## Interface
Parameters:
- WIDTH, 8, counter width in bits (≥2)

Ports:
- CLK  input  1  rising-edge clock; the only clock
- RST_N  input  1  asynchronous, active-low reset
- LOAD  input  1  synchronous load strobe; sampled on rising CLK
- D  input  WIDTH  load value, sampled when LOAD=1
- EN  input  1  count enable; decrement only when EN=1 in COUNT
- Q  output  WIDTH  current count (registered)
- BUSY  output  1  high while in COUNT
- DONE  output  1  one-cycle expiry pulse (high in EXPIRED)

## Operation
- Clock and reset:
  - One clock.
  - Reset is asynchronous and active-low: the block is reset immediately while RST_N=0, regardless of CLK.
- States: IDLE, COUNT, EXPIRED. The state is fully registered.
- Reset values:
  - Q=0, BUSY=0, DONE=0, state=IDLE.
  - Internal reload register RLD=0.
- Priority on every edge: LOAD > count/expiry logic. LOAD is honoured in any state.
- LOAD=1 on an edge:
  - RLD←D.
  - If D≠0: Q←D, state→COUNT.
  - If D=0: Q←0, state→EXPIRED.
- COUNT:
  - EN=0: Q holds.
  - EN=1 with Q>1: Q←Q−1.
  - EN=1 with Q=1: Q←0, state→EXPIRED.
- EXPIRED:
  - Lasts exactly one cycle, independent of EN.
  - Next state is IDLE, with Q remaining 0 (see Configuration for the auto-reload case).
- IDLE: Q holds 0; EN is ignored.
- Decrement structure:
  - Bit 0 toggles when EN·COUNT.
  - Bit i toggles when EN·COUNT and Q[i−1:0] are all zero (borrow chain, mirror of the up-counter carry chain).
  - Wrap-around below 0 is unreachable by construction. Q never underflows.
- Outputs are decoded from registered state only:
  - BUSY=(state==COUNT).
  - DONE=(state==EXPIRED).

## Timing
- LOAD→Q: 1 cycle. Q equals D after the edge that samples LOAD=1.
- From load of N≠0 with EN held high:
  - Q runs N, N−1, …, 1, 0.
  - DONE is high during the cycle where Q first reads 0, i.e. N edges after the load edge.
  - BUSY is high for N cycles.
- Load of D=0: DONE is high the cycle after the load edge; BUSY never asserts.
- Load during COUNT or EXPIRED: the new value takes effect on the same edge; the pending DONE is suppressed.
- EN deasserted mid-count stretches the count; it has no other effect.
- RST_N asserted mid-count: all outputs go to reset values immediately. On release, the block sits in IDLE until LOAD.
- No combinational path from inputs to outputs.

## Configuration
- Macro: SYNC_DOWN_TIMER8_AUTORELOAD_EN.
- Defined:
  - EXPIRED→COUNT with Q←RLD when RLD≠0.
  - With EN held high, DONE repeats every RLD+1 cycles.
  - RLD=0 still goes EXPIRED→IDLE.
- Not defined:
  - EXPIRED→IDLE always; single-shot.
  - RLD still exists but is unused.

## Test plan
- Reset: hold RST_N=0 for 3 cycles mid-count (Q=0x37) -> Q=0x00, BUSY=0, DONE=0 asynchronously; remains IDLE after release with EN=1.
- Single-shot: LOAD D=0x05, EN=1 -> Q=5,4,3,2,1,0 on consecutive cycles; DONE high exactly one cycle when Q=0; BUSY high 5 cycles; then IDLE, Q=0.
- Enable gating: LOAD D=0x03, EN toggles 1,0,0,1,1 -> Q=3,2,2,2,1,0; DONE on the final cycle only.
- Reload on the fly and boundary values:
  - LOAD D=0x80, count to Q=0x7E, then LOAD D=0xFF -> Q=0xFF next cycle, no DONE.
  - Counting through 0x80 produces 0x7F (borrow across all lower bits).
  - LOAD D=0x00 -> DONE next cycle, BUSY stays 0.
- Auto-reload (macro defined): LOAD D=0x02, EN=1 -> Q=2,1,0,2,1,0,…; DONE every 3 cycles. Without the macro: a single DONE, then Q stays 0.

Source files
------------

// File: rtl/sync_down_timer8_if.sv
// Bus bundle for the loadable down-timer: load strobe, load value and enable
// from the controller; count and status flags back from the timer.
interface sync_down_timer8_if #(
    parameter int WIDTH = 8
);
    logic             LOAD;
    logic [WIDTH-1:0] D;
    logic             EN;
    logic [WIDTH-1:0] Q;
    logic             BUSY;
    logic             DONE;

    // Controller side: drives load/enable, observes the count
    modport master (
        output LOAD,
        output D,
        output EN,
        input  Q,
        input  BUSY,
        input  DONE
    );

    // Timer side
    modport slave (
        input  LOAD,
        input  D,
        input  EN,
        output Q,
        output BUSY,
        output DONE
    );
endinterface

// File: rtl/sync_down_timer8.sv
// Loadable synchronous down-counter/timer built on a T-flip-flop borrow
// chain. Counts a loaded value to zero, pulses DONE for one cycle, then idles.
// Optional build macro SYNC_DOWN_TIMER8_AUTORELOAD_EN: on expiry, restart from
// the last loaded value (if non-zero) instead of idling.
module sync_down_timer8 #(
    parameter int WIDTH = 8
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    sync_down_timer8_if.slave      bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COUNT   = 2'd1,
        ST_EXPIRED = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] rld_q, rld_d;
    logic             busy_q;
    logic             done_q;

    logic             cnt_en;
    logic [WIDTH-1:0] tog;
    logic [WIDTH-1:0] q_dec;

    assign cnt_en = bus.EN && (state_q == ST_COUNT);

    // Borrow chain: bit i toggles when counting and every lower bit is zero
    assign tog[0] = cnt_en;
    generate
        for (genvar gi = 1; gi < WIDTH; gi++) begin : g_borrow
            assign tog[gi] = cnt_en && (q_q[gi-1:0] == '0);
        end
    endgenerate

    assign q_dec = q_q ^ tog;

    // Next-state decode: LOAD wins over counting/expiry in every state
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        rld_d   = rld_q;
        if (bus.LOAD) begin
            rld_d   = bus.D;
            q_d     = bus.D;
            state_d = (bus.D != '0) ? ST_COUNT : ST_EXPIRED;
        end else begin
            case (state_q)
                ST_COUNT: begin
                    if (bus.EN) begin
                        q_d = q_dec;
                        if (q_q == WIDTH'(1)) begin
                            state_d = ST_EXPIRED;
                        end
                    end
                end
                ST_EXPIRED: begin
`ifdef SYNC_DOWN_TIMER8_AUTORELOAD_EN
                    if (rld_q != '0) begin
                        q_d     = rld_q;
                        state_d = ST_COUNT;
                    end else begin
                        state_d = ST_IDLE;
                    end
`else
                    state_d = ST_IDLE;
`endif
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State, count, reload value and status flags all registered together
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            q_q     <= '0;
            rld_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            rld_q   <= rld_d;
            busy_q  <= (state_d == ST_COUNT);
            done_q  <= (state_d == ST_EXPIRED);
        end
    end

    assign bus.Q    = q_q;
    assign bus.BUSY = busy_q;
    assign bus.DONE = done_q;

endmodule

// File: tb/tb_sync_down_timer8.sv
// Directed bench for sync_down_timer8: reset, single-shot, enable gating,
// reload on the fly, borrow across bits, zero load and expiry behaviour.
module tb_sync_down_timer8;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    sync_down_timer8_if #(.WIDTH(8)) bus ();

    sync_down_timer8 #(.WIDTH(8)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // Advance one clock; leave sampling point 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [7:0] q, input logic busy, input logic done);
        check({tag, ".Q"},    32'(bus.Q),    32'(q));
        check({tag, ".BUSY"}, 32'(bus.BUSY), 32'(busy));
        check({tag, ".DONE"}, 32'(bus.DONE), 32'(done));
        $display("%-12s Q=0x%02h BUSY=%0b DONE=%0b", tag, bus.Q, bus.BUSY, bus.DONE);
    endtask

    task automatic do_load(input logic [7:0] v);
        bus.LOAD = 1'b1;
        bus.D    = v;
        tick();
        bus.LOAD = 1'b0;
        bus.D    = 8'h00;
    endtask

    logic [0:4] en_seq;
    logic [7:0] en_q[5];
    logic       en_done[5];

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        bus.LOAD = 1'b0;
        bus.D    = 8'h00;
        bus.EN   = 1'b0;

        // Reset state
        tick();
        tick();
        expect_out("reset", 8'h00, 1'b0, 1'b0);
        rst_n = 1'b1;
        bus.EN = 1'b1;
        tick();
        expect_out("idle_en", 8'h00, 1'b0, 1'b0);

        // Single shot from 5
        do_load(8'h05);
        expect_out("ss_load", 8'h05, 1'b1, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            expect_out($sformatf("ss_%0d", k), 8'(5 - k), 1'b1, 1'b0);
        end
        tick();
        expect_out("ss_done", 8'h00, 1'b0, 1'b1);
        tick();
`ifdef SYNC_DOWN_TIMER8_AUTORELOAD_EN
        expect_out("ss_after", 8'h05, 1'b1, 1'b0);
`else
        expect_out("ss_after", 8'h00, 1'b0, 1'b0);
        tick();
        expect_out("ss_idle", 8'h00, 1'b0, 1'b0);
`endif

        // Enable gating from 3
        en_seq  = 5'b10011;
        en_q    = '{8'h02, 8'h02, 8'h02, 8'h01, 8'h00};
        en_done = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        do_load(8'h03);
        expect_out("eg_load", 8'h03, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            bus.EN = en_seq[k];
            tick();
            expect_out($sformatf("eg_%0d", k), en_q[k], ~en_done[k], en_done[k]);
        end
        bus.EN = 1'b1;

        // Borrow across all lower bits, then reload on the fly
        do_load(8'h80);
        expect_out("b_load", 8'h80, 1'b1, 1'b0);
        tick();
        expect_out("b_7f", 8'h7F, 1'b1, 1'b0);
        tick();
        expect_out("b_7e", 8'h7E, 1'b1, 1'b0);
        do_load(8'hFF);
        expect_out("b_ff", 8'hFF, 1'b1, 1'b0);
        tick();
        expect_out("b_fe", 8'hFE, 1'b1, 1'b0);

        // Zero load: immediate expiry, never busy
        do_load(8'h00);
        expect_out("z_load", 8'h00, 1'b0, 1'b1);
        tick();
        expect_out("z_after", 8'h00, 1'b0, 1'b0);

        // Load during EXPIRED suppresses the idle transition
        do_load(8'h01);
        expect_out("x_load1", 8'h01, 1'b1, 1'b0);
        tick();
        expect_out("x_exp", 8'h00, 1'b0, 1'b1);
        do_load(8'h04);
        expect_out("x_reload", 8'h04, 1'b1, 1'b0);

        // Asynchronous reset mid-count
        do_load(8'h37);
        expect_out("r_load", 8'h37, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        expect_out("r_async", 8'h00, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        expect_out("r_hold", 8'h00, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        tick();
        expect_out("r_idle", 8'h00, 1'b0, 1'b0);

        // Expiry behaviour from 2
        do_load(8'h02);
        expect_out("ar_load", 8'h02, 1'b1, 1'b0);
        tick();
        expect_out("ar_1", 8'h01, 1'b1, 1'b0);
        tick();
        expect_out("ar_done", 8'h00, 1'b0, 1'b1);
`ifdef SYNC_DOWN_TIMER8_AUTORELOAD_EN
        tick();
        expect_out("ar_re2", 8'h02, 1'b1, 1'b0);
        tick();
        expect_out("ar_re1", 8'h01, 1'b1, 1'b0);
        tick();
        expect_out("ar_re0", 8'h00, 1'b0, 1'b1);
`else
        for (int k = 0; k < 3; k++) begin
            tick();
            expect_out($sformatf("ar_idle%0d", k), 8'h00, 1'b0, 1'b0);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
